// File: rtl/tt_slot_controller.sv
// tt_slot_controller: shares the user-I/O pads among NUM_SLOTS project slots.
// Define TT_SLOT_CTRL_OUT_REG_EN to register uo_out/uio_out/uio_oe (+1 cycle).
module tt_slot_controller #(
  parameter int NUM_SLOTS    = 4,
  parameter int RST_CYCLES   = 8,
  parameter int DRAIN_CYCLES = 2,
  localparam int IW = $clog2(NUM_SLOTS)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   sel_valid,
  input  logic                   sel_stop,
  input  logic [IW-1:0]          sel_idx,
  output logic                   sel_ready,
  output logic                   sel_err,
  output logic [IW-1:0]          active_idx,
  output logic                   running,
  output logic [NUM_SLOTS-1:0]   slot_ena,
  output logic [NUM_SLOTS-1:0]   slot_rst_n,
  input  logic [7:0]             ui_in,
  output logic [8*NUM_SLOTS-1:0] slot_ui_in,
  input  logic [7:0]             uio_in,
  output logic [8*NUM_SLOTS-1:0] slot_uio_in,
  input  logic [8*NUM_SLOTS-1:0] slot_uo_out,
  input  logic [8*NUM_SLOTS-1:0] slot_uio_out,
  input  logic [8*NUM_SLOTS-1:0] slot_uio_oe,
  output logic [7:0]             uo_out,
  output logic [7:0]             uio_out,
  output logic [7:0]             uio_oe
);

  localparam logic [7:0] RST_LOAD = 8'(RST_CYCLES - 1);
  localparam logic [7:0] DRN_LOAD = 8'(DRAIN_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE, S_DRAIN, S_RESET, S_RUN
  } state_t;

  state_t        state_q, state_d;
  logic [7:0]    cnt_q, cnt_d;
  logic [IW-1:0] act_q, act_d;
  logic [IW-1:0] pend_q, pend_d;
  logic          stop_q, stop_d;
  logic          err_q;
  logic          idx_bad;
  logic          accept;
  logic          run;
  logic [7:0]    pad_uo, pad_uio, pad_oe;

  assign idx_bad    = 32'(sel_idx) >= 32'(NUM_SLOTS);
  assign sel_ready  = (state_q == S_IDLE) || (state_q == S_RUN);
  assign accept     = sel_valid && sel_ready && (sel_stop || !idx_bad);
  assign run        = (state_q == S_RUN);
  assign running    = run;
  assign active_idx = act_q;
  assign sel_err    = err_q;

  // State, counter and selection registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      act_q   <= '0;
      pend_q  <= '0;
      stop_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      act_q   <= act_d;
      pend_q  <= pend_d;
      stop_q  <= stop_d;
      err_q   <= sel_valid && sel_ready &&
                 !sel_stop && idx_bad;
    end
  end

  // Next-state: select handshake, drain and reset sequencing
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    act_d   = act_q;
    pend_d  = pend_q;
    stop_d  = stop_q;
    unique case (state_q)
      S_IDLE: begin
        if (accept && !sel_stop) begin
          act_d   = sel_idx;
          cnt_d   = RST_LOAD;
          state_d = S_RESET;
        end
      end
      S_RESET: begin
        if (cnt_q == 8'd0) state_d = S_RUN;
        else cnt_d = cnt_q - 8'd1;
      end
      S_RUN: begin
        if (accept) begin
          pend_d  = sel_idx;
          stop_d  = sel_stop;
          cnt_d   = DRN_LOAD;
          state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (cnt_q != 8'd0) begin
          cnt_d = cnt_q - 8'd1;
        end else if (stop_q) begin
          state_d = S_IDLE;
        end else begin
          act_d   = pend_q;
          cnt_d   = RST_LOAD;
          state_d = S_RESET;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Owner-only ENA/RST_N, input fan-out and gated output mux
  always_comb begin
    slot_ena    = '0;
    slot_rst_n  = '0;
    slot_ui_in  = '0;
    slot_uio_in = '0;
    pad_uo      = '0;
    pad_uio     = '0;
    pad_oe      = '0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      if (state_q != S_IDLE && act_q == IW'(i)) begin
        slot_ena[i]         = 1'b1;
        slot_rst_n[i]       = run;
        slot_ui_in[i*8+:8]  = ui_in;
        slot_uio_in[i*8+:8] = uio_in;
        if (run) begin
          pad_uo  = slot_uo_out[i*8+:8];
          pad_uio = slot_uio_out[i*8+:8];
          pad_oe  = slot_uio_oe[i*8+:8];
        end
      end
    end
  end

`ifdef TT_SLOT_CTRL_OUT_REG_EN
  // Registered pad outputs; gating already applied upstream
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      uo_out  <= '0;
      uio_out <= '0;
      uio_oe  <= '0;
    end else begin
      uo_out  <= pad_uo;
      uio_out <= pad_uio;
      uio_oe  <= pad_oe;
    end
  end
`else
  assign uo_out  = pad_uo;
  assign uio_out = pad_uio;
  assign uio_oe  = pad_oe;
`endif

endmodule
